decoder_scan_seq: RTL



---
 rtl/decoder_scan_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/decoder_scan_seq.sv
// Scan sequencer for the 4-to-16 line decoder: walks a line range with a
// blanking cycle before each line and a programmable dwell per line.
module decoder_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [3:0]         first,
    input  logic [3:0]         last,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               en,
    output logic               busy,
    output logic               line_tick,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t             r_state;
    logic [3:0]         r_sel;
    logic [3:0]         r_first;
    logic [3:0]         r_last;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_cont;
    logic               r_stop_pend;
    logic               r_en;
    logic               r_busy;
    logic               r_line_tick;
    logic               r_done;

    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_stop_any;

    // A zero dwell behaves as one ON cycle; a stop seen on the line-end edge still counts
    assign w_dwell_eff = (dwell == {DWELL_W{1'b0}}) ? DWELL_ONE : dwell;
    assign w_stop_any  = r_stop_pend | stop;

    // Scan state machine with all status outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 4'd0;
            r_first     <= 4'd0;
            r_last      <= 4'd0;
            r_dwell     <= {DWELL_W{1'b0}};
            r_cnt       <= {DWELL_W{1'b0}};
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_line_tick <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_line_tick <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_en <= 1'b0;
                    if (start) begin
                        r_first     <= first;
                        r_last      <= last;
                        r_dwell     <= w_dwell_eff;
                        r_cont      <= continuous;
                        r_sel       <= first;
                        r_stop_pend <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_BLANK;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_BLANK: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end else begin
                        r_stop_pend <= r_stop_pend;
                    end
                    r_cnt   <= DWELL_ONE;
                    r_en    <= 1'b1;
                    r_state <= S_ON;
                end
                S_ON: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end else begin
                        r_stop_pend <= r_stop_pend;
                    end
                    if (r_cnt == r_dwell) begin
                        r_line_tick <= 1'b1;
                        r_en        <= 1'b0;
                        if (!w_stop_any && (r_sel != r_last)) begin
                            r_sel   <= r_sel + 4'd1;
                            r_state <= S_BLANK;
                        end else if (!w_stop_any && r_cont) begin
                            r_sel   <= r_first;
                            r_state <= S_BLANK;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + DWELL_ONE;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a         = r_sel[3];
    assign b         = r_sel[2];
    assign c         = r_sel[1];
    assign d         = r_sel[0];
    assign en        = r_en;
    assign busy      = r_busy;
    assign line_tick = r_line_tick;
    assign done      = r_done;

endmodule
